// File: rtl/pri_arbiter_pkg.sv
// Shared constants, FSM state type and helpers for the 8-way priority arbiter.
package pri_arbiter_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned ID_W  = 3;

  // The search pointer comes out of reset here, so index 7 is searched first.
  localparam logic [ID_W-1:0] PTR_RESET = 3'd7;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

  // One-hot decode of a requester index.
  function automatic logic [N_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    logic [N_REQ-1:0] vec;
    vec     = '0;
    vec[id] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/pri_arbiter_enc.sv
// Rotating priority encoder: finds the first set bit of eff, searching downward
// from index ptr and wrapping from 0 to 7.
module pri_arbiter_enc
  import pri_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] eff,
  input  logic [ID_W-1:0]  ptr,
  output logic [ID_W-1:0]  winner,
  output logic             any
);

  logic [ID_W-1:0]    shamt;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [ID_W-1:0]    hi_idx;

  // Rotate left by (7 - ptr) so the pointer position lands on bit 7, then the
  // plain highest-bit encoder gives the right search order.
  always_comb begin
    shamt = 3'd7 - ptr;
    dbl   = {eff, eff} << shamt;
    rot   = dbl[2*N_REQ-1:N_REQ];
  end

  // Highest set bit of the rotated vector; later iterations win.
  always_comb begin
    hi_idx = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      if (rot[i]) begin
        hi_idx = ID_W'(i);
      end
    end
  end

  // Undo the rotation; 3-bit arithmetic provides the mod-8 wrap.
  always_comb begin
    winner = hi_idx - shamt;
    any    = |eff;
  end

endmodule

// File: rtl/pri_arbiter.sv
// 8-requester arbiter with fixed or rotating priority. A grant is held until
// the owner releases, the owner drops its request, or the hold limit expires.
// owner_release carries the "release" input; that name is a reserved word.
module pri_arbiter
  import pri_arbiter_pkg::*;
#(
  parameter bit          RR_EN    = 1'b0,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] mask,
  input  logic             owner_release,
  output logic [N_REQ-1:0] gnt,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_valid,
  output logic             timeout
);

  localparam int unsigned HOLD_W = (MAX_HOLD == 0) ? 1 : $clog2(MAX_HOLD + 1);
  localparam bit          TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
      HOLD_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);

  state_e             state_q, state_d;
  logic [N_REQ-1:0]   gnt_q, gnt_d;
  logic [ID_W-1:0]    gnt_id_q, gnt_id_d;
  logic               timeout_q, timeout_d;
  logic [HOLD_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [ID_W-1:0]    ptr_q, ptr_d;

  logic [N_REQ-1:0]   eff;
  logic [ID_W-1:0]    winner;
  logic               any;
  logic               exit_rel, exit_wd, exit_to, exit_any;

  assign eff = req & ~mask;

  pri_arbiter_enc u_enc (
    .eff    (eff),
    .ptr    (ptr_q),
    .winner (winner),
    .any    (any)
  );

  // Exit conditions while holding a grant; withdrawal looks at raw req, not eff,
  // so masking the owner never revokes it.
  always_comb begin
    exit_rel = owner_release;
    exit_wd  = ~req[gnt_id_q];
    exit_to  = TIMEOUT_EN && (hold_cnt_q == HOLD_LAST);
    exit_any = exit_rel | exit_wd | exit_to;
  end

  // State register plus all registered outputs and bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
      ptr_q      <= PTR_RESET;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      timeout_q  <= timeout_d;
      hold_cnt_q <= hold_cnt_d;
      ptr_q      <= ptr_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          state_d = StGrant;
        end
      end
      StGrant: begin
        if (exit_any) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values of the registered outputs, hold counter and search pointer.
  always_comb begin
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    timeout_d  = 1'b0;
    hold_cnt_d = hold_cnt_q;
    ptr_d      = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          gnt_d      = onehot(winner);
          gnt_id_d   = winner;
          hold_cnt_d = '0;
          // Rotating mode makes the new owner the lowest priority next time.
          ptr_d      = RR_EN ? (winner - 3'd1) : PTR_RESET;
        end else begin
          gnt_d = '0;
        end
      end
      StGrant: begin
        if (exit_any) begin
          gnt_d      = '0;
          hold_cnt_d = '0;
          // Pulse only when the limit alone forced the revoke.
          timeout_d  = exit_to & ~exit_rel & ~exit_wd;
        end else if (hold_cnt_q != '1) begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: begin
        gnt_d = '0;
      end
    endcase
  end

  assign gnt       = gnt_q;
  assign gnt_id    = gnt_id_q;
  assign gnt_valid = |gnt_q;
  assign timeout   = timeout_q;

`ifndef SYNTHESIS
  // Grant vector is always one-hot or zero, and idle means no grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(gnt_q));
      assert ((state_q == StGrant) || (gnt_q == '0));
    end
  end
`endif

endmodule

// File: tb/tb_pri_arbiter.sv
// Scoreboard bench for pri_arbiter: two instances (fixed priority with a short
// hold limit, and rotating priority with the default limit). Stimulus pushes
// the expected grant record; a monitor pops and checks at every grant end.
module tb_pri_arbiter;

  typedef struct {
    int id;
    int start;
    int len;
    bit to;
    bit rst_drop;
  } exp_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;

  logic [7:0] req_v [2];
  logic [7:0] mask_v [2];
  logic       rel_v [2];
  logic       rst_v [2];
  logic [7:0] gnt_v [2];
  logic [2:0] id_v [2];
  logic       vld_v [2];
  logic       to_v [2];

  exp_t       exp_q [2][$];
  bit         act [2];
  int         st [2];
  logic [7:0] g0 [2];
  logic [2:0] id0 [2];

  pri_arbiter #(.RR_EN(1'b0), .MAX_HOLD(4)) u_fix (
    .clk           (clk),
    .rst           (rst_v[0]),
    .req           (req_v[0]),
    .mask          (mask_v[0]),
    .owner_release (rel_v[0]),
    .gnt           (gnt_v[0]),
    .gnt_id        (id_v[0]),
    .gnt_valid     (vld_v[0]),
    .timeout       (to_v[0])
  );

  pri_arbiter #(.RR_EN(1'b1), .MAX_HOLD(16)) u_rr (
    .clk           (clk),
    .rst           (rst_v[1]),
    .req           (req_v[1]),
    .mask          (mask_v[1]),
    .owner_release (rel_v[1]),
    .gnt           (gnt_v[1]),
    .gnt_id        (id_v[1]),
    .gnt_valid     (vld_v[1]),
    .timeout       (to_v[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int i, input int id, input int start, input int len,
                      input bit to, input bit rd);
    exp_t e;
    e.id = id; e.start = start; e.len = len; e.to = to; e.rst_drop = rd;
    exp_q[i].push_back(e);
  endtask

  // Drive a request in an idle cycle, hold the grant len cycles, releasing in the last.
  task automatic grant_rel(input int i, input logic [7:0] r, input logic [7:0] m,
                           input int id, input int len);
    req_v[i]  = r;
    mask_v[i] = m;
    push(i, id, cyc + 1, len, 1'b0, 1'b0);
    tick();
    for (int k = 1; k < len; k++) tick();
    rel_v[i] = 1'b1;
    tick();
    rel_v[i] = 1'b0;
  endtask

  task automatic mon(input int i);
    exp_t       e;
    logic [7:0] oh;
    chk($sformatf("gnt_valid[%0d]", i), 32'(vld_v[i]), 32'(gnt_v[i] != 8'h00));
    if (vld_v[i] && !act[i]) begin
      act[i] = 1'b1;
      st[i]  = cyc;
      g0[i]  = gnt_v[i];
      id0[i] = id_v[i];
      chk($sformatf("timeout_at_start[%0d]", i), 32'(to_v[i]), 32'd0);
    end else if (vld_v[i] && act[i]) begin
      chk($sformatf("gnt_stable[%0d]", i), 32'(gnt_v[i]), 32'(g0[i]));
      chk($sformatf("timeout_in_grant[%0d]", i), 32'(to_v[i]), 32'd0);
    end else if (!vld_v[i] && act[i]) begin
      act[i] = 1'b0;
      n_chk++;
      if (exp_q[i].size() == 0) begin
        $display("FAIL unexpected_grant[%0d]: got id %0d required none (cycle %0d)",
                 i, id0[i], cyc);
      end else begin
        n_pass++;
        e  = exp_q[i].pop_front();
        oh = 8'h01 << e.id;
        chk($sformatf("gnt_id[%0d]", i), 32'(id0[i]), 32'(e.id));
        chk($sformatf("gnt_onehot[%0d]", i), 32'(g0[i]), 32'(oh));
        chk($sformatf("grant_start[%0d]", i), 32'(st[i]), 32'(e.start));
        chk($sformatf("grant_len[%0d]", i), 32'(cyc - st[i]), 32'(e.len));
        chk($sformatf("timeout_at_drop[%0d]", i), 32'(to_v[i]), 32'(e.to));
        chk($sformatf("id_after_drop[%0d]", i), 32'(id_v[i]),
            e.rst_drop ? 32'd0 : 32'(e.id));
      end
    end
  endtask

  always @(negedge clk) begin
    if (cyc > 2) begin
      for (int i = 0; i < 2; i++) mon(i);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    for (int i = 0; i < 2; i++) begin
      req_v[i] = '0; mask_v[i] = '0; rel_v[i] = 1'b0; rst_v[i] = 1'b1;
      act[i] = 1'b0; st[i] = 0; g0[i] = '0; id0[i] = '0;
    end
    tick();
    tick();
    rst_v[0] = 1'b0;
    rst_v[1] = 1'b0;
    @(negedge clk);
    chk("reset_gnt", 32'(gnt_v[0]), 32'd0);
    chk("reset_gnt_id", 32'(id_v[0]), 32'd0);
    chk("reset_gnt_valid", 32'(vld_v[0]), 32'd0);
    chk("reset_timeout", 32'(to_v[0]), 32'd0);
    tick();

    // Fixed priority: highest index wins.
    grant_rel(0, 8'b01010000, 8'h00, 6, 2);
    grant_rel(0, 8'b10001001, 8'h00, 7, 2);
    grant_rel(0, 8'b00100100, 8'h00, 5, 3);

    // Mask selects 3; masking everything mid-grant keeps the owner.
    req_v[0] = 8'b10001001; mask_v[0] = 8'b11110000;
    push(0, 3, cyc + 1, 3, 1'b0, 1'b0);
    tick();
    mask_v[0] = 8'hFF;
    tick();
    tick();
    rel_v[0] = 1'b1;
    tick();
    rel_v[0] = 1'b0; mask_v[0] = 8'h00; req_v[0] = 8'h00;

    // Hold limit of 4: two forced revokes with one idle cycle between.
    req_v[0] = 8'b00000001;
    push(0, 0, cyc + 1, 4, 1'b1, 1'b0);
    push(0, 0, cyc + 6, 4, 1'b1, 1'b0);
    repeat (10) tick();
    req_v[0] = 8'h00;

    // Release on the final hold cycle: no timeout pulse.
    grant_rel(0, 8'b00000010, 8'h00, 1, 4);

    // Withdrawal of the owner, then the remaining requester.
    req_v[0] = 8'b10000001;
    push(0, 7, cyc + 1, 2, 1'b0, 1'b0);
    tick();
    tick();
    req_v[0] = 8'b00000001;
    push(0, 0, cyc + 2, 2, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    rel_v[0] = 1'b1;
    tick();
    rel_v[0] = 1'b0; req_v[0] = 8'h00;

    // Rotating priority with every requester active.
    grant_rel(1, 8'hFF, 8'h00, 7, 2);
    grant_rel(1, 8'hFF, 8'h00, 6, 2);
    grant_rel(1, 8'hFF, 8'h00, 5, 2);
    grant_rel(1, 8'hFF, 8'h00, 4, 2);
    grant_rel(1, 8'hFF, 8'h00, 3, 2);
    grant_rel(1, 8'hFF, 8'h00, 2, 2);
    grant_rel(1, 8'hFF, 8'h00, 1, 2);
    grant_rel(1, 8'hFF, 8'h00, 0, 2);
    grant_rel(1, 8'hFF, 8'h00, 7, 2);
    grant_rel(1, 8'b10000001, 8'h00, 0, 2);
    grant_rel(1, 8'b10000001, 8'h00, 7, 2);

    // Reset mid-grant restores the pointer: 6 wins again rather than 4.
    req_v[1] = 8'b01010000;
    t = cyc;
    push(1, 6, t + 1, 2, 1'b0, 1'b1);
    tick();
    tick();
    rst_v[1] = 1'b1;
    tick();
    rst_v[1] = 1'b0;
    @(negedge clk);
    chk("rst_mid_gnt", 32'(gnt_v[1]), 32'd0);
    chk("rst_mid_gnt_id", 32'(id_v[1]), 32'd0);
    chk("rst_mid_timeout", 32'(to_v[1]), 32'd0);
    push(1, 6, t + 4, 1, 1'b0, 1'b0);
    tick();
    rel_v[1] = 1'b1;
    tick();
    rel_v[1] = 1'b0; req_v[1] = 8'h00;

    repeat (4) tick();
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("pending_expected[%0d]", i), 32'(exp_q[i].size()), 32'd0);
      chk($sformatf("grant_left_open[%0d]", i), 32'(act[i]), 32'd0);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
